// File: rtl/uart_rx_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word_buffer
//  Description : Edge-captured UART byte FIFO with on-request word assembly.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_word_buffer #(
    parameter  int DEPTH      = 8192,
    parameter  int WORD_BYTES = 4,
    parameter  int BIG_ENDIAN = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    flush,
    input  logic                    req,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic                    word_valid,
    output logic                    busy,
    output logic [AW:0]             count,
    output logic                    overflow
);

    localparam logic [AW:0] c_FULL     = (AW+1)'(DEPTH);
    localparam logic [2:0]  c_LAST_IDX = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_rx_valid_d;
    logic [7:0]              r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [2:0]              r_byte_idx;
    logic [8*WORD_BYTES-1:0] r_shadow;
    logic [8*WORD_BYTES-1:0] w_shadow_next;
    logic [8*WORD_BYTES-1:0] r_word_data;
    logic                    r_word_valid;
    logic                    r_overflow;
    logic                    w_push_edge;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_last;
    logic [2:0]              w_lane;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign w_push_edge = rx_valid & ~r_rx_valid_d;
    assign w_pop       = (r_state == S_ASSEMBLE) && (r_count != '0);
    assign w_push      = w_push_edge && ((r_count != c_FULL) || w_pop);
    assign w_last      = w_pop && (r_byte_idx == c_LAST_IDX);
    assign w_lane      = (BIG_ENDIAN != 0) ? (c_LAST_IDX - r_byte_idx) : r_byte_idx;

    always_comb begin
        w_shadow_next                    = r_shadow;
        w_shadow_next[{w_lane, 3'b000} +: 8] = r_mem[r_rd_ptr];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (req) w_state_next = S_ASSEMBLE;
            S_ASSEMBLE: if (w_last) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid_d <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_byte_idx   <= '0;
            r_shadow     <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_valid_d <= rx_valid;
            r_word_valid <= 1'b0;
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_byte_idx <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + AW'(1);
                    r_shadow   <= w_shadow_next;
                    r_byte_idx <= r_byte_idx + 3'd1;
                end
                // Word output and its valid pulse land together, one cycle after the last pop.
                if (w_last) begin
                    r_word_data  <= w_shadow_next;
                    r_word_valid <= 1'b1;
                    r_byte_idx   <= '0;
                end
                if (r_state == S_IDLE && req) r_byte_idx <= '0;
                if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
                else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
                if (w_push_edge && !w_push) r_overflow <= 1'b1;
            end
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign busy       = (r_state != S_IDLE);
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_word_buffer
//  Description : Directed self-checking bench, little- and big-endian instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_buffer;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        flush;
    logic        req;
    logic [31:0] word_data_le, word_data_be;
    logic        word_valid_le, word_valid_be;
    logic        busy_le, busy_be;
    logic [3:0]  count_le, count_be;
    logic        overflow_le, overflow_be;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_word_buffer #(.DEPTH(8), .WORD_BYTES(4), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .flush(flush), .req(req), .word_data(word_data_le),
        .word_valid(word_valid_le), .busy(busy_le), .count(count_le),
        .overflow(overflow_le)
    );

    uart_rx_word_buffer #(.DEPTH(8), .WORD_BYTES(4), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .flush(flush), .req(req), .word_data(word_data_be),
        .word_valid(word_valid_be), .busy(busy_be), .count(count_be),
        .overflow(overflow_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    // Pulses req for one cycle, then observes cycles 1..10 after it.
    task automatic run_req(output int vcyc, output int npulse,
                           output logic [31:0] dle, output logic [31:0] dbe,
                           output logic [9:0] bmask);
        vcyc = 0; npulse = 0; dle = '0; dbe = '0; bmask = '0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bmask[k-1] = busy_le;
            if (word_valid_le) begin
                npulse++;
                if (vcyc == 0) begin
                    vcyc = k;
                    dle  = word_data_le;
                    dbe  = word_data_be;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A; flush = 1'b0; req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({word_data_le, word_valid_le, busy_le, count_le, overflow_le} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b busy=%b count=%0d ovf=%b, expected all zero",
                     word_data_le, word_valid_le, busy_le, count_le, overflow_le);
        end
        tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd0 || count_be !== 4'd0) begin
            n_fail++;
            $display("FAIL held_level_no_push: count le=%0d be=%0d, expected 0", count_le, count_be);
        end
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic test_assemble();
        int vcyc, npulse;
        logic [31:0] dle, dbe;
        logic [9:0] bmask;
        send_byte(8'h11, 3); send_byte(8'h22, 3); send_byte(8'h33, 3); send_byte(8'h44, 3);
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd4) begin
            n_fail++;
            $display("FAIL count_after_4: got %0d, expected 4", count_le);
        end
        tick();
        run_req(vcyc, npulse, dle, dbe, bmask);
        n_checks++;
        if (vcyc !== 5 || npulse !== 1) begin
            n_fail++;
            $display("FAIL latency: valid cycle=%0d pulses=%0d, expected 5 and 1", vcyc, npulse);
        end
        n_checks++;
        if (dle !== 32'h44332211) begin
            n_fail++;
            $display("FAIL word_le: got %h, expected 44332211", dle);
        end
        n_checks++;
        if (dbe !== 32'h11223344) begin
            n_fail++;
            $display("FAIL word_be: got %h, expected 11223344", dbe);
        end
        n_checks++;
        if (bmask !== 10'b00000_11111) begin
            n_fail++;
            $display("FAIL busy_window: got %b, expected 0000011111", bmask);
        end
        n_checks++;
        if (count_le !== 4'd0) begin
            n_fail++;
            $display("FAIL count_drained: got %0d, expected 0", count_le);
        end
    endtask

    task automatic test_empty_stall();
        logic [7:0] bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int bad = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 9; j++) begin
                @(negedge clk);
                if (!busy_le || word_valid_le) bad++;
                if (i == 1 && j == 3) req = 1'b1;
                @(posedge clk);
                #1;
                req = 1'b0;
            end
            rx_data  = bytes[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
        end
        @(negedge clk);
        if (!busy_le || word_valid_le) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_busy: got %0d bad cycles, expected 0", bad);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (word_valid_le !== 1'b1 || word_data_le !== 32'hD4C3B2A1 || word_data_be !== 32'hA1B2C3D4) begin
            n_fail++;
            $display("FAIL stall_word: valid=%b le=%h be=%h, expected 1 D4C3B2A1 A1B2C3D4",
                     word_valid_le, word_data_le, word_data_be);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (word_valid_le !== 1'b0 || busy_le !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: valid=%b busy=%b, expected 0 0", word_valid_le, busy_le);
        end
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (busy_le !== 1'b0) begin
            n_fail++;
            $display("FAIL req_not_queued: busy=%b, expected 0", busy_le);
        end
        tick();
    endtask

    task automatic test_overflow();
        int vcyc = 0;
        logic [31:0] dle = '0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1);
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd8 || overflow_le !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: count=%0d ovf=%b, expected 8 0", count_le, overflow_le);
        end
        tick();
        send_byte(8'h09, 1);
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd8 || overflow_le !== 1'b1 || overflow_be !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_on_full: count=%0d ovf=%b/%b, expected 8 1", count_le, overflow_le, overflow_be);
        end
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd8) begin
            n_fail++;
            $display("FAIL push_pop_at_full: count=%0d, expected 8", count_le);
        end
        for (int k = 2; k <= 10; k++) begin
            if (k > 2) @(negedge clk);
            if (word_valid_le && vcyc == 0) begin
                vcyc = k;
                dle  = word_data_le;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (vcyc !== 5 || dle !== 32'h04030201) begin
            n_fail++;
            $display("FAIL full_word: cycle=%0d data=%h, expected 5 04030201", vcyc, dle);
        end
        @(negedge clk);
        n_checks++;
        if (count_le !== 4'd5 || overflow_le !== 1'b1) begin
            n_fail++;
            $display("FAIL after_full_word: count=%0d ovf=%b, expected 5 1", count_le, overflow_le);
        end
        tick();
    endtask

    task automatic test_flush();
        int pulses = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        flush    = 1'b1;
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (word_valid_le) pulses++;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pulses !== 0 || busy_le !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_abort: pulses=%0d busy=%b, expected 0 0", pulses, busy_le);
        end
        n_checks++;
        if (count_le !== 4'd0 || overflow_le !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: count=%0d ovf=%b, expected 0 0", count_le, overflow_le);
        end
        n_checks++;
        if (word_data_le !== 32'h04030201 || word_data_be !== 32'h01020304) begin
            n_fail++;
            $display("FAIL flush_word_kept: le=%h be=%h, expected 04030201 01020304",
                     word_data_le, word_data_be);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_le [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        logic [31:0] exp_be [3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        int vcyc, npulse;
        logic [31:0] dle, dbe;
        logic [9:0] bmask;
        for (int r = 0; r < 3; r++) begin
            for (int b = 1; b <= 4; b++) send_byte(8'(4*r + b), 2);
            run_req(vcyc, npulse, dle, dbe, bmask);
            n_checks++;
            if (vcyc !== 5 || npulse !== 1 || dle !== exp_le[r] || dbe !== exp_be[r]) begin
                n_fail++;
                $display("FAIL wrap_round%0d: cycle=%0d pulses=%0d le=%h be=%h, expected 5 1 %h %h",
                         r, vcyc, npulse, dle, dbe, exp_le[r], exp_be[r]);
            end
            n_checks++;
            if (count_le !== 4'd0) begin
                n_fail++;
                $display("FAIL wrap_count%0d: got %0d, expected 0", r, count_le);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; flush = 1'b0; req = 1'b0;
        test_reset();
        test_assemble();
        test_empty_stall();
        test_overflow();
        test_flush();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
